and_unit_arbiter: RTL
=====================

Name: and_unit_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational AND datapath between NUM_REQ requesters.
- Holds each winner's operands stable on the shared datapath for one cycle, then captures the result.
- Returns the result with the winner's ID over a valid/ready response channel.
- Sits between the requesting agents and the shared AND gate instance; it is the only driver of the gate's inputs.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- WIDTH, 1: operand/result width in bits.
- ID_W, $clog2(NUM_REQ): width of rsp_id (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low: rst=0 resets immediately, rst=1 runs.
- req  in  NUM_REQ  per-requester request; held high until that requester's gnt bit is seen.
- a_in  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- b_in  in  NUM_REQ*WIDTH  operand B; same packing as a_in.
- gnt  out  NUM_REQ  one-hot grant pulse.
- dp_a  out  WIDTH  operand A driven to the shared AND datapath (registered).
- dp_b  out  WIDTH  operand B driven to the shared AND datapath (registered).
- dp_y  in  WIDTH  result from the shared datapath; must equal dp_a & dp_b combinationally.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted by the consumer.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_data  out  WIDTH  captured result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; round-robin pointer ptr=0.
  - gnt=0, dp_a=0, dp_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - Reset asserted mid-operation abandons the transaction: no response is produced, and ptr returns to 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise the winner w is the first index i with req[i]=1, scanning ptr, ptr+1, … and wrapping modulo NUM_REQ.
  - At the same edge: gnt <= onehot(w); dp_a <= a_in[w]; dp_b <= b_in[w]; wid <= w; go to EXEC.
- EXEC (exactly 1 cycle):
  - gnt is high for this cycle only; dp_a and dp_b are stable.
  - At the end-of-cycle edge: rsp_data <= dp_y; rsp_id <= wid; rsp_valid <= 1; gnt <= 0; ptr <= (wid+1) mod NUM_REQ; go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held constant until the handshake.
  - When rsp_valid & rsp_ready at a posedge: rsp_valid <= 0 and go to IDLE.
  - No new grant is issued while in RESP. Request changes during EXEC/RESP are ignored until IDLE.
- dp_a/dp_b keep their last value outside EXEC (no toggling).
- Latency:
  - req sampled at edge t0 → gnt high during cycle t0+1 → rsp_valid high from edge t0+2.
  - Minimum 3 cycles per transaction with rsp_ready tied high.
- Fairness:
  - A requester holding req continuously is granted within NUM_REQ transactions.
  - The most recent winner has the lowest priority in the next arbitration.
- Requesters must drop req in the cycle after seeing gnt if they have no further work. A req still high in IDLE is treated as a new request.
- A single requester requesting continuously is served back-to-back: one transaction per 3 cycles.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req=4'b1111 → gnt=0, busy=0, rsp_valid=0; release rst; first grant is gnt=4'b0001.
- Single op: NUM_REQ=4, req=4'b0100, a_in[2]=1, b_in[2]=1, rsp_ready=1 → gnt=4'b0100 for exactly 1 cycle; 2 cycles after req is sampled, rsp_valid=1 with rsp_id=2, rsp_data=1. Repeat with b_in[2]=0 → rsp_data=0.
- Round-robin: req=4'b1111 held for 4 transactions → grant order 0,1,2,3; then req=4'b1001 → next grants are 0, 3, 0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid, rsp_id and rsp_data stay stable and gnt stays 0 throughout; the first cycle with rsp_ready=1 completes, and the next grant follows on the next IDLE edge.
- Mid-op reset: pull rst low during EXEC → all outputs go to 0 immediately, no response appears after release, and the next grant starts from ptr=0.
- Wrap: WIDTH=4, only requester 3 requesting with a=4'hA, b=4'h6 → rsp_data=4'h2, rsp_id=3; the next arbitration scans from ptr=0.

Source files
------------

// File: rtl/and_unit_arbiter.sv
// and_unit_arbiter: round-robin sequencer sharing one AND datapath among NUM_REQ requesters,
// returning each result with its winner id over a valid/ready channel.
module and_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH = 1,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   a_in,
    input  logic [NUM_REQ*WIDTH-1:0]   b_in,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]           dp_a,
    output logic [WIDTH-1:0]           dp_b,
    input  logic [WIDTH-1:0]           dp_y,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [ID_W:0]      NREQ    = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]    LAST    = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] GNT_ONE = NUM_REQ'(1);

    state_t               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d, wid_q, wid_d, rsp_id_q, rsp_id_d, win;
    logic [ID_W:0]        scan;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]     dp_a_q, dp_a_d, dp_b_q, dp_b_d, rsp_data_q, rsp_data_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]     a_arr [NUM_REQ];
    logic [WIDTH-1:0]     b_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = a_in[g*WIDTH +: WIDTH];
        assign b_arr[g] = b_in[g*WIDTH +: WIDTH];
    end

    // Scan from the far end back toward ptr so the closest requester after ptr wins.
    always_comb begin
        win  = '0;
        scan = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (scan >= NREQ) scan = scan - NREQ;
            if (req[scan[ID_W-1:0]]) win = scan[ID_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        wid_d       = wid_q;
        gnt_d       = '0;
        dp_a_d      = dp_a_q;
        dp_b_d      = dp_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: if (|req) begin
                gnt_d   = GNT_ONE << win;
                dp_a_d  = a_arr[win];
                dp_b_d  = b_arr[win];
                wid_d   = win;
                state_d = EXEC;
            end
            EXEC: begin
                rsp_data_d  = dp_y;
                rsp_id_d    = wid_q;
                rsp_valid_d = 1'b1;
                ptr_d       = (wid_q == LAST) ? '0 : wid_q + 1'b1;
                state_d     = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            wid_q       <= '0;
            gnt_q       <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wid_q       <= wid_d;
            gnt_q       <= gnt_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign gnt       = gnt_q;
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = state_q != IDLE;
endmodule
